// File: rtl/lc3_trace_capture.sv
// Per-instruction commit tracer for the lc3 core: builds one PennSim-style record per retired
// instruction and queues it in a first-word-fall-through FIFO. Optional macro: TRACE_OVFL_COUNT_EN.
module lc3_trace_capture #(
    parameter int          DEPTH       = 16,
    parameter logic [5:0]  FETCH_STATE = 6'd18,
    parameter int          AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          trace_en,
    input  logic          flush,
    input  logic [5:0]    dbg_next_state,
    input  logic [15:0]   dbg_pc,
    input  logic [15:0]   dbg_instruction,
    input  logic          dbg_ldreg,
    input  logic [15:0]   dbg_databus,
    input  logic          dbg_mioen,
    input  logic [15:0]   dbg_mar,
    input  logic [15:0]   dbg_mdr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [81:0]   out_record,
    output logic [AW:0]   level,
    output logic          overflow
`ifdef TRACE_OVFL_COUNT_EN
    ,
    output logic [15:0]   ovfl_count
`endif
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic          fetch_now;
    logic          fetch_d;
    logic          cp;
    logic          armed;
    logic [15:0]   insn_pc;
    logic          ldreg_acc;
    logic [15:0]   regin_acc;
    logic          mio_acc;
    logic [15:0]   mar_acc;
    logic [15:0]   mdr_acc;

    logic          rec_ldreg;
    logic [15:0]   rec_regin;
    logic          rec_mio;
    logic [15:0]   rec_mar;
    logic [15:0]   rec_mdr;
    logic [81:0]   rec;

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          do_write;
    logic          drop;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [81:0]   mem [DEPTH];

    // Flags raised in the commit cycle itself still belong to the instruction that is retiring.
    always_comb begin
        fetch_now = (dbg_next_state == FETCH_STATE);
        cp        = fetch_now & ~fetch_d;
        rec_ldreg = ldreg_acc | dbg_ldreg;
        rec_regin = dbg_ldreg ? dbg_databus : regin_acc;
        rec_mio   = mio_acc | dbg_mioen;
        rec_mar   = dbg_mioen ? dbg_mar : mar_acc;
        rec_mdr   = dbg_mioen ? dbg_mdr : mdr_acc;
        rec       = {insn_pc, dbg_instruction, rec_ldreg, rec_regin, rec_mio, rec_mar, rec_mdr};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_d   <= 1'b0;
            armed     <= 1'b0;
            insn_pc   <= '0;
            ldreg_acc <= 1'b0;
            regin_acc <= '0;
            mio_acc   <= 1'b0;
            mar_acc   <= '0;
            mdr_acc   <= '0;
        end else begin
            fetch_d <= fetch_now;
            if (cp) begin
                armed     <= 1'b1;
                insn_pc   <= dbg_pc;
                ldreg_acc <= 1'b0;
                regin_acc <= '0;
                mio_acc   <= 1'b0;
                mar_acc   <= '0;
                mdr_acc   <= '0;
            end else begin
                if (dbg_ldreg) begin
                    ldreg_acc <= 1'b1;
                    regin_acc <= dbg_databus;
                end
                if (dbg_mioen) begin
                    mio_acc <= 1'b1;
                    mar_acc <= dbg_mar;
                    mdr_acc <= dbg_mdr;
                end
            end
        end
    end

    // When full, a simultaneous pop frees the slot being written, so the push is still taken.
    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        out_valid  = ~empty;
        pop        = out_valid & out_ready;
        push       = cp & armed & trace_en;
        do_write   = push & ~flush & (~full | pop);
        drop       = push & ~flush & full & ~pop;
        level      = wr_ptr - rd_ptr;
        out_record = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= rec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef TRACE_OVFL_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovfl_count <= '0;
        end else if (flush) begin
            ovfl_count <= '0;
        end else if (drop && (ovfl_count != 16'hFFFF)) begin
            ovfl_count <= ovfl_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lc3_trace_capture.sv
// Self-checking bench for lc3_trace_capture: directed vector table, fill/flush and reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_lc3_trace_capture;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          reset_n;
    logic          trace_en;
    logic          flush;
    logic [5:0]    dbg_next_state;
    logic [15:0]   dbg_pc;
    logic [15:0]   dbg_instruction;
    logic          dbg_ldreg;
    logic [15:0]   dbg_databus;
    logic          dbg_mioen;
    logic [15:0]   dbg_mar;
    logic [15:0]   dbg_mdr;
    logic          out_valid;
    logic          out_ready;
    logic [81:0]   out_record;
    logic [AW:0]   level;
    logic          overflow;
`ifdef TRACE_OVFL_COUNT_EN
    logic [15:0]   ovfl_count;
`endif

    int checks   = 0;
    int failures = 0;

    lc3_trace_capture #(.DEPTH(DEPTH), .FETCH_STATE(6'd18)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .trace_en        (trace_en),
        .flush           (flush),
        .dbg_next_state  (dbg_next_state),
        .dbg_pc          (dbg_pc),
        .dbg_instruction (dbg_instruction),
        .dbg_ldreg       (dbg_ldreg),
        .dbg_databus     (dbg_databus),
        .dbg_mioen       (dbg_mioen),
        .dbg_mar         (dbg_mar),
        .dbg_mdr         (dbg_mdr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_record      (out_record),
        .level           (level),
        .overflow        (overflow)
`ifdef TRACE_OVFL_COUNT_EN
        ,
        .ovfl_count      (ovfl_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction currently in flight plus a queue of finished records.
    logic [81:0]   mq[$];
    bit            m_armed;
    bit            m_fetch_d;
    logic [15:0]   m_pc;
    bit            m_ld;
    logic [15:0]   m_regin;
    bit            m_mio;
    logic [15:0]   m_mar;
    logic [15:0]   m_mdr;
    bit            m_ovf;
    logic [15:0]   m_cnt;

    function automatic logic [81:0] mkrec(input logic [15:0] pc, input logic [15:0] ir,
                                          input logic ld, input logic [15:0] regin,
                                          input logic mio, input logic [15:0] mar,
                                          input logic [15:0] mdr);
        return {pc, ir, ld, regin, mio, mar, mdr};
    endfunction

    task automatic modelReset();
        mq.delete();
        m_armed   = 0;
        m_fetch_d = 0;
        m_pc      = '0;
        m_ld      = 0;
        m_regin   = '0;
        m_mio     = 0;
        m_mar     = '0;
        m_mdr     = '0;
        m_ovf     = 0;
        m_cnt     = '0;
    endtask

    task automatic idleInputs();
        dbg_next_state  = 6'd0;
        dbg_ldreg       = 1'b0;
        dbg_databus     = '0;
        dbg_mioen       = 1'b0;
        dbg_mar         = '0;
        dbg_mdr         = '0;
        flush           = 1'b0;
    endtask

    // One clock with the currently driven inputs; the model advances on the same edge.
    task automatic applyStimulus();
        bit          fetch;
        bit          cp;
        bit          pop;
        bit          push;
        logic [81:0] r;
        logic [81:0] tmp;
        @(posedge clk);
        fetch = (dbg_next_state == 6'd18);
        cp    = fetch && !m_fetch_d;
        pop   = (mq.size() > 0) && out_ready;
        r     = mkrec(m_pc, dbg_instruction, m_ld | dbg_ldreg,
                      dbg_ldreg ? dbg_databus : m_regin,
                      m_mio | dbg_mioen,
                      dbg_mioen ? dbg_mar : m_mar,
                      dbg_mioen ? dbg_mdr : m_mdr);
        push  = cp && m_armed && trace_en;
        if (flush) begin
            mq.delete();
            m_ovf = 0;
            m_cnt = '0;
        end else begin
            if (pop) tmp = mq.pop_front();
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(r);
                else begin
                    m_ovf = 1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
            end
        end
        if (cp) begin
            m_armed = 1;
            m_pc    = dbg_pc;
            m_ld    = 0;
            m_regin = '0;
            m_mio   = 0;
            m_mar   = '0;
            m_mdr   = '0;
        end else begin
            if (dbg_ldreg) begin
                m_ld    = 1;
                m_regin = dbg_databus;
            end
            if (dbg_mioen) begin
                m_mio = 1;
                m_mar = dbg_mar;
                m_mdr = dbg_mdr;
            end
        end
        m_fetch_d = fetch;
        @(negedge clk);
    endtask

    task automatic checkValue(input string name, input logic [81:0] act, input logic [81:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        checkValue({name, ".valid"}, 82'(out_valid), 82'(mq.size() > 0));
        checkValue({name, ".level"}, 82'(level), 82'(mq.size()));
        checkValue({name, ".record"}, out_record, (mq.size() > 0) ? mq[0] : 82'd0);
        checkValue({name, ".overflow"}, 82'(overflow), 82'(m_ovf));
`ifdef TRACE_OVFL_COUNT_EN
        checkValue({name, ".ovfl_count"}, 82'(ovfl_count), 82'(m_cnt));
`endif
    endtask

    task automatic commit(input logic [15:0] pc, input logic [15:0] ir);
        idleInputs();
        dbg_next_state  = 6'd18;
        dbg_pc          = pc;
        dbg_instruction = ir;
        applyStimulus();
        dbg_next_state  = 6'd0;
        applyStimulus();
    endtask

    typedef struct {
        logic [5:0]  ns;
        logic [15:0] pc;
        logic [15:0] ir;
        logic        ld;
        logic [15:0] bus;
        logic        mio;
        logic [15:0] mar;
        logic [15:0] mdr;
        logic        rdy;
        logic        ev;
        logic [4:0]  elev;
        logic [81:0] erec;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [81:0] r1, r2, r3, r4, rr;

        reset_n         = 1'b0;
        trace_en        = 1'b1;
        out_ready       = 1'b0;
        dbg_pc          = '0;
        dbg_instruction = '0;
        idleInputs();
        modelReset();

        r1 = mkrec(16'h3000, 16'h1261, 1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0000);
        r2 = mkrec(16'h3001, 16'h7000, 1'b0, 16'h0000, 1'b1, 16'h4000, 16'hABCD);
        r3 = mkrec(16'h3002, 16'h1234, 1'b1, 16'h7777, 1'b0, 16'h0000, 16'h0000);
        r4 = mkrec(16'h3003, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        vecs[0] = '{6'd18, 16'h3000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd0, 82'd0};
        vecs[1] = '{6'd0,  16'h3000, 16'h0000, 1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd0, 82'd0};
        vecs[2] = '{6'd18, 16'h3001, 16'h1261, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 5'd1, r1};
        vecs[3] = '{6'd0,  16'h3001, 16'h1261, 1'b0, 16'h0000, 1'b1, 16'h4000, 16'hABCD, 1'b0, 1'b1, 5'd1, r1};
        vecs[4] = '{6'd18, 16'h3002, 16'h7000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 5'd2, r1};
        vecs[5] = '{6'd0,  16'h3002, 16'h7000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 5'd1, r2};
        vecs[6] = '{6'd18, 16'h3003, 16'h1234, 1'b1, 16'h7777, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 5'd1, r3};
        vecs[7] = '{6'd0,  16'h3003, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 5'd1, r3};
        vecs[8] = '{6'd18, 16'h3004, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 5'd1, r4};
        vecs[9] = '{6'd0,  16'h3004, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 5'd0, 82'd0};

        #12;
        checkValue("reset.valid", 82'(out_valid), 82'd0);
        checkValue("reset.record", out_record, 82'd0);
        checkValue("reset.level", 82'(level), 82'd0);
        checkValue("reset.overflow", 82'(overflow), 82'd0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            dbg_next_state  = vecs[i].ns;
            dbg_pc          = vecs[i].pc;
            dbg_instruction = vecs[i].ir;
            dbg_ldreg       = vecs[i].ld;
            dbg_databus     = vecs[i].bus;
            dbg_mioen       = vecs[i].mio;
            dbg_mar         = vecs[i].mar;
            dbg_mdr         = vecs[i].mdr;
            out_ready       = vecs[i].rdy;
            applyStimulus();
            checkValue($sformatf("vec%0d.valid", i), 82'(out_valid), 82'(vecs[i].ev));
            checkValue($sformatf("vec%0d.level", i), 82'(level), 82'(vecs[i].elev));
            checkValue($sformatf("vec%0d.record", i), out_record, vecs[i].erec);
            checkOutput($sformatf("vec%0d.model", i));
        end

        $display("[TB] fill past full, push+pop at full, drain, flush");
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            commit(16'h4000 + 16'(i), 16'h1000 + 16'(i));
        end
        checkValue("fill.level", 82'(level), 82'd16);
        checkValue("fill.overflow", 82'(overflow), 82'd1);
        checkValue("fill.head", out_record,
                   mkrec(16'h3004, 16'h1000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000));
`ifdef TRACE_OVFL_COUNT_EN
        checkValue("fill.ovfl_count", 82'(ovfl_count), 82'd2);
`endif
        checkOutput("fill.model");

        idleInputs();
        dbg_next_state  = 6'd18;
        dbg_pc          = 16'h5000;
        dbg_instruction = 16'hAAAA;
        out_ready       = 1'b1;
        applyStimulus();
        checkValue("pushpop.level", 82'(level), 82'd16);
        checkValue("pushpop.head", out_record,
                   mkrec(16'h4000, 16'h1001, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000));
`ifdef TRACE_OVFL_COUNT_EN
        checkValue("pushpop.ovfl_count", 82'(ovfl_count), 82'd2);
`endif
        checkOutput("pushpop.model");

        dbg_next_state = 6'd0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus();
            checkOutput($sformatf("drain%0d", i));
        end
        checkValue("drain.level", 82'(level), 82'd0);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) commit(16'h5100 + 16'(i), 16'h2000 + 16'(i));
        dbg_next_state = 6'd18;
        dbg_pc         = 16'h5200;
        flush          = 1'b1;
        applyStimulus();
        checkValue("flush.level", 82'(level), 82'd0);
        checkValue("flush.valid", 82'(out_valid), 82'd0);
        checkValue("flush.overflow", 82'(overflow), 82'd0);
`ifdef TRACE_OVFL_COUNT_EN
        checkValue("flush.ovfl_count", 82'(ovfl_count), 82'd0);
`endif
        idleInputs();
        applyStimulus();
        checkOutput("postflush");

        $display("[TB] reset mid-instruction");
        commit(16'h5300, 16'h3000);
        dbg_ldreg   = 1'b1;
        dbg_databus = 16'h9999;
        applyStimulus();
        reset_n = 1'b0;
        modelReset();
        #1;
        checkValue("midreset.valid", 82'(out_valid), 82'd0);
        checkValue("midreset.level", 82'(level), 82'd0);
        checkValue("midreset.record", out_record, 82'd0);
        checkValue("midreset.overflow", 82'(overflow), 82'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idleInputs();
        commit(16'h6000, 16'h0000);
        checkValue("rearm.level", 82'(level), 82'd0);
        dbg_mioen = 1'b1;
        dbg_mar   = 16'h1234;
        dbg_mdr   = 16'h5678;
        applyStimulus();
        idleInputs();
        dbg_next_state  = 6'd18;
        dbg_pc          = 16'h6001;
        dbg_instruction = 16'h2222;
        applyStimulus();
        rr = mkrec(16'h6000, 16'h2222, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h5678);
        checkValue("rearm.record", out_record, rr);
        checkValue("rearm.level2", 82'(level), 82'd1);

        $display("[TB] randomized traffic");
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 1500; i++) begin
                dbg_next_state  = ($urandom_range(0, 3) == 0) ? 6'd18 : 6'($urandom_range(0, 63));
                dbg_pc          = 16'($urandom);
                dbg_instruction = 16'($urandom);
                dbg_ldreg       = ($urandom_range(0, 3) == 0);
                dbg_databus     = 16'($urandom);
                dbg_mioen       = ($urandom_range(0, 3) == 0);
                dbg_mar         = 16'($urandom);
                dbg_mdr         = 16'($urandom);
                trace_en        = ($urandom_range(0, 9) != 0);
                flush           = ($urandom_range(0, 199) == 0);
                out_ready       = (phase == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
                applyStimulus();
                checkOutput($sformatf("rand%0d_%0d", phase, i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
